// File: rtl/track_row_dma.sv
// Streams one buffered track row per frame into text VRAM, started by the vsync falling edge.
// Latency: the first write is on the bus one cycle after the vsync fall; with no stalls a row takes ROW_WORDS cycles.
// Backpressure: IN_READY drops while the FIFO is full; AVM_WAITREQUEST holds the bus and blocks the FIFO pop.
//
// Ports:
//   CLK, RESET            : clock and synchronous active-high reset
//   VS                    : active-low vsync, synchronous to CLK
//   IN_VALID/IN_DATA      : word input to the row FIFO
//   IN_READY              : the row FIFO can take a word this cycle
//   AVM_*                 : Avalon-MM write master towards the VRAM slave
//   ROW_PTR               : next row slot to be written; the display uses it as the scroll offset
//   BUSY                  : a row burst is in progress
//   UNDERRUN_CNT          : saturating count of frames that had less than a row buffered

// Generic synchronous first-word-fall-through FIFO with an occupancy count.
// Latency: a pushed word is visible at dout on the next cycle.
// Backpressure: a push while full and a pop while empty are both ignored.
module track_row_dma_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 32,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign push_ok = push && (count_q != CW'(DEPTH));
  assign pop_ok  = pop && (count_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    if (pop_ok)  rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone says what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= din;
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
endmodule

module track_row_dma #(
  parameter int ROW_WORDS  = 20,
  parameter int NUM_ROWS   = 30,
  parameter int FIFO_DEPTH = 32,
  parameter int ADDR_W     = 10
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              VS,
  input  logic              IN_VALID,
  input  logic [31:0]       IN_DATA,
  output logic              IN_READY,
  output logic              AVM_CS,
  output logic              AVM_WRITE,
  output logic [ADDR_W-1:0] AVM_ADDR,
  output logic [3:0]        AVM_BYTE_EN,
  output logic [31:0]       AVM_WRITEDATA,
  input  logic              AVM_WAITREQUEST,
  output logic [4:0]        ROW_PTR,
  output logic              BUSY,
  output logic [7:0]        UNDERRUN_CNT
);
  localparam int CW  = $clog2(FIFO_DEPTH + 1);
  localparam int WCW = $clog2(ROW_WORDS);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_WRITE = 1'b1;

  logic [0:0]     state_q, state_d;
  logic           vs_q, vs_d;
  logic [WCW-1:0] word_cnt_q, word_cnt_d;
  logic [4:0]     row_ptr_q, row_ptr_d;
  logic [7:0]     underrun_q, underrun_d;

  logic [CW-1:0]     fifo_count;
  logic [31:0]       fifo_head;
  logic              fifo_push, vs_fall, in_write, accept, last_word;
  logic [ADDR_W-1:0] row_addr;

  assign IN_READY  = (fifo_count < CW'(FIFO_DEPTH));
  assign fifo_push = IN_VALID && IN_READY;
  assign vs_fall   = vs_q && !VS;
  assign in_write  = (state_q == ST_WRITE);
  // A word leaves the FIFO only when the slave takes it, so a stall holds head and address.
  assign accept    = in_write && !AVM_WAITREQUEST;
  assign last_word = (word_cnt_q == WCW'(ROW_WORDS - 1));

  track_row_dma_fifo #(
    .W     (32),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (fifo_push),
    .pop   (accept),
    .din   (IN_DATA),
    .dout  (fifo_head),
    .count (fifo_count)
  );

  always_comb begin
    state_d    = state_q;
    vs_d       = VS;
    word_cnt_d = word_cnt_q;
    row_ptr_d  = row_ptr_q;
    underrun_d = underrun_q;
    case (state_q)
      ST_IDLE: begin
        if (vs_fall) begin
          if (fifo_count >= CW'(ROW_WORDS)) begin
            state_d    = ST_WRITE;
            word_cnt_d = '0;
          end else if (underrun_q != 8'hFF) begin
            underrun_d = underrun_q + 1'b1;
          end
        end
      end
      default: begin
        // vsync edges are deliberately ignored while a row is in flight.
        if (accept) begin
          if (last_word) begin
            state_d    = ST_IDLE;
            word_cnt_d = '0;
            row_ptr_d  = (row_ptr_q == 5'(NUM_ROWS - 1)) ? 5'd0 : row_ptr_q + 5'd1;
          end else begin
            word_cnt_d = word_cnt_q + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= ST_IDLE;
      vs_q       <= 1'b1;
      word_cnt_q <= '0;
      row_ptr_q  <= '0;
      underrun_q <= '0;
    end else begin
      state_q    <= state_d;
      vs_q       <= vs_d;
      word_cnt_q <= word_cnt_d;
      row_ptr_q  <= row_ptr_d;
      underrun_q <= underrun_d;
    end
  end

  // Slot base plus word offset stays below NUM_ROWS*ROW_WORDS, clear of the control region.
  assign row_addr = ADDR_W'(row_ptr_q) * ADDR_W'(ROW_WORDS) + ADDR_W'(word_cnt_q);

  assign AVM_CS        = in_write;
  assign AVM_WRITE     = in_write;
  assign BUSY          = in_write;
  assign AVM_BYTE_EN   = 4'b1111;
  assign AVM_ADDR      = in_write ? row_addr : '0;
  assign AVM_WRITEDATA = in_write ? fifo_head : 32'd0;
  assign ROW_PTR       = row_ptr_q;
  assign UNDERRUN_CNT  = underrun_q;
endmodule
